ext_world_io_agent: RTL and testbench
=====================================

// Module: ext_world_io_agent
// PURPOSE
// - External-world side of the RISCProcessor I/O ports: drives InpExtWorld1..4 from host writes, captures OutExtWorld1..4 on each OUTportWrite.
// - Captured snapshots are queued in a FIFO and streamed to the host over a valid/ready interface.
// - Sits between the processor top and the board/testbench host; the processor itself is unmodified.
// PARAMETERS
// - DEPTH      8      snapshot FIFO entries; power of 2, >= 2
// - INP_RESET  8'h00  reset value of all four InpExtWorld registers
// PORTS
// - clk            in   1   single clock, rising edge
// - Reset          in   1   asynchronous, active-low reset
// - OutExtWorld1   in   8   processor output port 1
// - OutExtWorld2   in   8   processor output port 2
// - OutExtWorld3   in   8   processor output port 3
// - OutExtWorld4   in   8   processor output port 4
// - OUTportWrite   in   1   processor output-port write strobe, 1 cycle per OUT instruction
// - InpExtWorld1   out  8   processor input port 1 (registered)
// - InpExtWorld2   out  8   processor input port 2 (registered)
// - InpExtWorld3   out  8   processor input port 3 (registered)
// - InpExtWorld4   out  8   processor input port 4 (registered)
// - host_wr_en     in   1   host write to an input port register
// - host_wr_addr   in   2   0..3 selects InpExtWorld1..4
// - host_wr_data   in   8   value to load
// - m_valid        out  1   FIFO head valid
// - m_ready        in   1   host accepts head when m_valid & m_ready
// - m_data         out  32  {OutExtWorld4,OutExtWorld3,OutExtWorld2,OutExtWorld1} snapshot
// - m_seq          out  8   snapshot sequence number, wraps 255->0
// - ovf_count      out  8   dropped snapshots, saturates at 255
// - ovf_clr        in   1   clears ovf_count and ovf_sticky
// - ovf_sticky     out  1   set on any drop, held until ovf_clr or reset
// BEHAVIOUR
// - Reset low (async): InpExtWorld* = INP_RESET, FIFO empty, m_valid=0, m_data=0, m_seq=0, seq counter=0,
//   ovf_count=0, ovf_sticky=0, pending strobe cleared; all take effect immediately, no clock needed.
// - Input side: host_wr_en at edge N -> selected InpExtWorld updates at N; others hold. One write per cycle.
// - Capture: OUTportWrite seen at edge N is registered (pend); ports sampled at edge N+1 (processor output
//   regs settle after the write edge). Back-to-back strobes produce one snapshot each, in order.
// - Push: sampled snapshot + current seq counter written to FIFO at N+1; seq counter increments per push.
// - Latency: FIFO empty, OUTportWrite at edge N -> m_valid=1 after edge N+2, m_data/m_seq stable while m_valid.
// - Pop on m_valid & m_ready; next entry (if any) presented the following cycle; m_valid falls when empty.
// - m_valid must not drop and m_data must not change while m_valid=1 & m_ready=0.
// - Full: push without simultaneous pop is dropped; seq counter still increments (host sees gap);
//   ovf_count +1 (saturating), ovf_sticky=1.
// - Full with simultaneous pop: push accepted, no drop; occupancy unchanged.
// - Empty with push: no pop possible same cycle (head not yet valid); no fall-through.
// - ovf_clr coinciding with a drop: drop wins -> ovf_count=1, ovf_sticky=1.
// - Pointers wrap modulo DEPTH; occupancy counter 0..DEPTH distinguishes full from empty.
// - Reset mid-transfer: queued and pending snapshots discarded; host must re-sync on m_seq=0.
// CONFIGURATION
// - CHANGE_FILTER_EN defined: snapshot pushed only if it differs from last pushed snapshot (compare reg
//   resets to 0); suppressed snapshots do not increment seq and never count as drops.
// - CHANGE_FILTER_EN undefined: every OUTportWrite produces a push attempt; compare logic absent.
// TESTING
// - Reset low, host writes addr2=8'h5A, release -> InpExtWorld3=8'h5A next edge, others=INP_RESET.
// - Ports=11,22,33,44, OUTportWrite pulse at edge N, m_ready=1 -> m_valid at N+2, m_data=32'h44332211, m_seq=0.
// - m_ready=0, DEPTH+2 strobes -> DEPTH entries held, ovf_count=2, ovf_sticky=1, drained m_seq 0..DEPTH-1.
// - FIFO full, strobe and pop same cycle -> no drop, ovf_count unchanged, new entry last in order.
// - CHANGE_FILTER_EN: two strobes with identical ports -> one entry; change port1 to 8'h01 -> second entry m_seq=1.
// - Reset asserted with 3 entries queued -> m_valid=0 immediately; next capture returns m_seq=0.

Source files
------------

// File: rtl/ext_world_io_agent_if.sv
// Snapshot stream from ext_world_io_agent to the host.
// master: the agent (drives valid/data/seq); slave: the host (drives ready).
interface ext_world_io_agent_if;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [7:0]  m_seq;

    modport master (output m_valid, output m_data, output m_seq, input m_ready);
    modport slave  (input m_valid, input m_data, input m_seq, output m_ready);
endinterface

// File: rtl/ext_world_io_agent.sv
// ext_world_io_agent: external-world side of the RISCProcessor I/O ports.
// Host writes drive InpExtWorld1..4. Every OUTportWrite captures OutExtWorld1..4
// one cycle later into a DEPTH-entry snapshot FIFO. Each snapshot is tagged with
// a sequence number. The FIFO streams to the host over a valid/ready interface.
// Optional feature: define CHANGE_FILTER_EN to push only snapshots that differ
// from the last one that passed the filter.
module ext_world_io_agent #(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] INP_RESET = 8'h00
) (
    input  logic                        clk,
    input  logic                        Reset,
    input  logic [7:0]                  OutExtWorld1,
    input  logic [7:0]                  OutExtWorld2,
    input  logic [7:0]                  OutExtWorld3,
    input  logic [7:0]                  OutExtWorld4,
    input  logic                        OUTportWrite,
    output logic [7:0]                  InpExtWorld1,
    output logic [7:0]                  InpExtWorld2,
    output logic [7:0]                  InpExtWorld3,
    output logic [7:0]                  InpExtWorld4,
    input  logic                        host_wr_en,
    input  logic [1:0]                  host_wr_addr,
    input  logic [7:0]                  host_wr_data,
    ext_world_io_agent_if.master        m_if,
    output logic [7:0]                  ovf_count,
    input  logic                        ovf_clr,
    output logic                        ovf_sticky
);
    localparam int             AW       = $clog2(DEPTH);
    localparam int             CW       = AW + 1;
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

    logic [7:0]    inp_q [4];
    logic          pend_q;
    logic [7:0]    seq_q,  seq_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    logic [7:0]    ovf_cnt_q, ovf_cnt_d;
    logic          ovf_stk_q, ovf_stk_d;
    logic [39:0]   mem_q [DEPTH];

    logic [31:0]   snap;
    logic [39:0]   head;
    logic          attempt, pop, full, push_ok, drop;

    // Host-writable input port registers, one per port.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_inp
            always_ff @(posedge clk or negedge Reset) begin
                if (!Reset)
                    inp_q[gi] <= INP_RESET;
                else if (host_wr_en && (host_wr_addr == 2'(gi)))
                    inp_q[gi] <= host_wr_data;
            end
        end
    endgenerate

    assign InpExtWorld1 = inp_q[0];
    assign InpExtWorld2 = inp_q[1];
    assign InpExtWorld3 = inp_q[2];
    assign InpExtWorld4 = inp_q[3];

    assign snap = {OutExtWorld4, OutExtWorld3, OutExtWorld2, OutExtWorld1};
    assign head = mem_q[rd_ptr_q];

`ifdef CHANGE_FILTER_EN
    logic [31:0] last_q;

    // Remember the last snapshot that passed the filter; suppressed ones leave it alone.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset)
            last_q <= 32'h0;
        else if (attempt)
            last_q <= snap;
    end

    assign attempt = pend_q && (snap != last_q);
`else
    assign attempt = pend_q;
`endif

    // FIFO bookkeeping, sequence counter and overflow accounting.
    always_comb begin
        pop       = valid_q && m_if.m_ready;
        full      = (count_q == FULL_CNT);
        push_ok   = attempt && (!full || pop);
        drop      = attempt && full && !pop;
        wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q + CW'(push_ok) - CW'(pop);
        // Only entries present before this edge become visible, so an empty
        // FIFO never falls through; after a pop the next entry shows at once.
        valid_d   = (count_q > CW'(pop));
        seq_d     = seq_q + 8'(attempt);
        ovf_cnt_d = ovf_cnt_q;
        ovf_stk_d = ovf_stk_q;
        if (drop) begin
            ovf_cnt_d = (ovf_cnt_q == 8'hFF) ? 8'hFF : ovf_cnt_q + 8'd1;
            ovf_stk_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_cnt_d = 8'h00;
            ovf_stk_d = 1'b0;
        end
    end

    // Control state: strobe delay stage, pointers, occupancy, counters.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            pend_q    <= 1'b0;
            seq_q     <= 8'h00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            ovf_cnt_q <= 8'h00;
            ovf_stk_q <= 1'b0;
        end else begin
            pend_q    <= OUTportWrite;
            seq_q     <= seq_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            ovf_cnt_q <= ovf_cnt_d;
            ovf_stk_q <= ovf_stk_d;
        end
    end

    // Snapshot storage; contents are meaningless until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= {seq_q, snap};
    end

    assign m_if.m_valid = valid_q;
    assign m_if.m_data  = valid_q ? head[31:0]  : 32'h0;
    assign m_if.m_seq   = valid_q ? head[39:32] : 8'h00;
    assign ovf_count    = ovf_cnt_q;
    assign ovf_sticky   = ovf_stk_q;
endmodule

// File: tb/tb_ext_world_io_agent.sv
module tb_ext_world_io_agent;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       Reset;
    logic [7:0] OutExtWorld1, OutExtWorld2, OutExtWorld3, OutExtWorld4;
    logic       OUTportWrite;
    logic [7:0] InpExtWorld1, InpExtWorld2, InpExtWorld3, InpExtWorld4;
    logic       host_wr_en;
    logic [1:0] host_wr_addr;
    logic [7:0] host_wr_data;
    logic [7:0] ovf_count;
    logic       ovf_clr;
    logic       ovf_sticky;

    ext_world_io_agent_if bus ();

    ext_world_io_agent #(.DEPTH(DEPTH), .INP_RESET(8'h00)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .OutExtWorld1 (OutExtWorld1),
        .OutExtWorld2 (OutExtWorld2),
        .OutExtWorld3 (OutExtWorld3),
        .OutExtWorld4 (OutExtWorld4),
        .OUTportWrite (OUTportWrite),
        .InpExtWorld1 (InpExtWorld1),
        .InpExtWorld2 (InpExtWorld2),
        .InpExtWorld3 (InpExtWorld3),
        .InpExtWorld4 (InpExtWorld4),
        .host_wr_en   (host_wr_en),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .m_if         (bus.master),
        .ovf_count    (ovf_count),
        .ovf_clr      (ovf_clr),
        .ovf_sticky   (ovf_sticky)
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;
    logic [39:0] sb_q[$];

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {8'h40 + b, 8'h30 + b, 8'h20 + b, 8'h10 + b};
    endfunction

    function automatic logic [31:0] inp_all();
        return {InpExtWorld4, InpExtWorld3, InpExtWorld2, InpExtWorld1};
    endfunction

    task automatic set_ports(input logic [31:0] v);
        {OutExtWorld4, OutExtWorld3, OutExtWorld2, OutExtWorld1} = v;
    endtask

    // n back-to-back strobes; strobe i captures pat(base+i)
    task automatic burst(input int n, input int base);
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            OUTportWrite = (i < n);
            if (i >= 1) set_ports(pat(base + i - 1));
        end
        OUTportWrite = 1'b0;
    endtask

    // one strobe with the given port values
    task automatic strobe(input logic [31:0] v);
        @(negedge clk);
        set_ports(v);
        OUTportWrite = 1'b1;
        @(negedge clk);
        OUTportWrite = 1'b0;
    endtask

    // wait (bounded) for a head, compare with the scoreboard front, pop it
    task automatic pop_check(input string tag);
        logic [39:0] exp;
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.m_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_valid"}, {39'h0, bus.m_valid}, 40'h1);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 40'hxx_xxxx_xxxx;
        chk(tag, {bus.m_seq, bus.m_data}, exp);
        $display("pop %s seq=%0d data=%h", tag, bus.m_seq, bus.m_data);
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        Reset        = 1'b0;
        OUTportWrite = 1'b0;
        set_ports(32'h0);
        host_wr_en   = 1'b1;
        host_wr_addr = 2'd2;
        host_wr_data = 8'h5A;
        ovf_clr      = 1'b0;
        bus.m_ready  = 1'b0;

        // reset state; the pending host write must not land while in reset
        repeat (3) @(negedge clk);
        chk("rst_inp", {8'h0, inp_all()}, 40'h0);
        chk("rst_valid", {39'h0, bus.m_valid}, 40'h0);
        chk("rst_head", {bus.m_seq, bus.m_data}, 40'h0);
        chk("rst_ovf", {31'h0, ovf_sticky, ovf_count}, 40'h0);

        // host write lands on the first edge after release
        Reset = 1'b1;
        @(posedge clk); #1;
        chk("inp3_5a", {8'h0, inp_all()}, {8'h0, 32'h005A0000});
        @(negedge clk);
        host_wr_addr = 2'd0;
        host_wr_data = 8'hA1;
        @(negedge clk);
        host_wr_en   = 1'b0;
        host_wr_addr = 2'd1;
        host_wr_data = 8'h77;
        @(negedge clk);
        chk("inp1_a1", {8'h0, inp_all()}, {8'h0, 32'h005A00A1});

        // capture latency: strobe at edge N -> m_valid after N+2
        set_ports(32'h44332211);
        bus.m_ready = 1'b1;
        @(negedge clk);
        OUTportWrite = 1'b1;
        @(posedge clk);
        @(negedge clk);
        OUTportWrite = 1'b0;
        chk("lat_n", {39'h0, bus.m_valid}, 40'h0);
        @(posedge clk); #1;
        chk("lat_n1", {39'h0, bus.m_valid}, 40'h0);
        @(posedge clk); #1;
        chk("lat_n2_valid", {39'h0, bus.m_valid}, 40'h1);
        chk("lat_n2_head", {bus.m_seq, bus.m_data}, {8'h00, 32'h44332211});
        $display("capture seq=%0d data=%h", bus.m_seq, bus.m_data);
        @(posedge clk); #1;
        chk("lat_popped", {7'h0, bus.m_valid, bus.m_data}, 40'h0);
        @(negedge clk);
        bus.m_ready = 1'b0;

        // fresh start, then overflow: DEPTH+2 strobes with the host stalled
        Reset = 1'b0;
        @(negedge clk);
        Reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) sb_q.push_back({8'(i), pat(i)});
        burst(DEPTH + 2, 0);
        repeat (3) @(negedge clk);
        chk("ovf_count2", {32'h0, ovf_count}, 40'd2);
        chk("ovf_sticky", {39'h0, ovf_sticky}, 40'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_head", {7'h0, bus.m_valid, bus.m_seq, bus.m_data}, {1'b1, sb_q[0]});
        end

        // full: strobe whose push edge coincides with a pop -> accepted
        @(negedge clk);
        set_ports(pat(100));
        OUTportWrite = 1'b1;
        @(negedge clk);
        OUTportWrite = 1'b0;
        chk("fullpop_head", {bus.m_seq, bus.m_data}, sb_q[0]);
        void'(sb_q.pop_front());
        sb_q.push_back({8'd10, pat(100)});
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("fullpop_ovf", {32'h0, ovf_count}, 40'd2);
        repeat (DEPTH) pop_check("drain");
        repeat (2) @(negedge clk);
        chk("drain_empty", {39'h0, bus.m_valid}, 40'h0);

        // clear
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", {31'h0, ovf_sticky, ovf_count}, 40'h0);

        // refill, then a drop coinciding with ovf_clr: drop wins
        for (int i = 0; i < DEPTH; i++) sb_q.push_back({8'(11 + i), pat(200 + i)});
        burst(DEPTH, 200);
        @(negedge clk);
        set_ports(pat(250));
        OUTportWrite = 1'b1;
        @(negedge clk);
        OUTportWrite = 1'b0;
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("clr_vs_drop", {31'h0, ovf_sticky, ovf_count}, {31'h0, 1'b1, 8'd1});
        repeat (5) pop_check("part");

        // reset with 3 entries queued: immediate, no clock edge needed
        @(negedge clk);
        #2 Reset = 1'b0;
        #1;
        chk("rst_mid_valid", {39'h0, bus.m_valid}, 40'h0);
        chk("rst_mid_head", {bus.m_seq, bus.m_data}, 40'h0);
        chk("rst_mid_ovf", {31'h0, ovf_sticky, ovf_count}, 40'h0);
        chk("rst_mid_inp", {8'h0, inp_all()}, 40'h0);
        sb_q.delete();
        @(negedge clk);
        Reset = 1'b1;
        sb_q.push_back({8'd0, 32'hCAFEF00D});
        strobe(32'hCAFEF00D);
        pop_check("post_reset");

        // two identical strobes, then port1 changes
        Reset = 1'b0;
        @(negedge clk);
        Reset = 1'b1;
`ifdef CHANGE_FILTER_EN
        sb_q.push_back({8'd0, 32'h44332211});
        sb_q.push_back({8'd1, 32'h44332201});
`else
        sb_q.push_back({8'd0, 32'h44332211});
        sb_q.push_back({8'd1, 32'h44332211});
        sb_q.push_back({8'd2, 32'h44332201});
`endif
        strobe(32'h44332211);
        strobe(32'h44332211);
        strobe(32'h44332201);
        while (sb_q.size() > 0) pop_check("filter");
        repeat (4) @(negedge clk);
        chk("filter_empty", {39'h0, bus.m_valid}, 40'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
